// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-enable BRAM behind valid/ready request and response
// channels, with store lane alignment, load shift/extend and a response FIFO.
module dmem_ctrl #(
    parameter  int DEPTH     = 4096,
    parameter  int XLEN      = 32,
    parameter  int OUT_DEPTH = 2,
    localparam int NB        = XLEN / 8,
    localparam int OFFW      = $clog2(NB),
    localparam int AW        = $clog2(DEPTH * NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_we
);
    localparam int WIW = AW - OFFW;
    localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW  = $clog2(OUT_DEPTH + 1);
    localparam int FW  = XLEN + 2;

    // Handshake: a request transfers on a clk edge where req_valid && req_ready,
    // a response transfers where rsp_valid && rsp_ready; neither depends on the
    // other side's valid, and response fields hold while rsp_valid && !rsp_ready.

    logic [OFFW-1:0] req_off;
    logic [WIW-1:0]  req_widx;
    logic [3:0]      req_nbytes;
    logic            req_bad;
    logic            accept;
    logic [NB-1:0]   lane_we;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] rd_word;

    assign req_off    = req_addr[OFFW-1:0];
    assign req_widx   = req_addr[AW-1:OFFW];
    assign req_nbytes = 4'd1 << req_size;
    assign accept     = req_valid && req_ready;

    always_comb begin
        req_bad = |(req_off & OFFW'(req_nbytes - 4'd1));
        if (req_size == 2'b11 && XLEN == 32) req_bad = 1'b1;
    end

    // Each lane takes the request byte at (lane mod size), i.e. the store data
    // replicated across the word; only the lanes covered by the access are enabled.
    always_comb begin
        lane_we   = '0;
        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            lane_we[i] = accept && req_we && !req_bad &&
                         (i >= int'(req_off)) && (i < int'(req_off) + int'(req_nbytes));
            wdata_rep[8*i +: 8] = req_wdata[8*(i % int'(req_nbytes)) +: 8];
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (lane_we[g]) mem_q[req_widx] <= wdata_rep[8*g +: 8];
            if (accept) rd_q <= mem_q[req_widx];
        end

        assign rd_word[8*g +: 8] = rd_q;
    end

    logic            s1_valid_q;
    logic            s1_we_q;
    logic            s1_err_q;
    logic            s1_uns_q;
    logic [1:0]      s1_size_q;
    logic [OFFW-1:0] s1_off_q;

    always_ff @(posedge clk) begin
        if (rst) s1_valid_q <= 1'b0;
        else     s1_valid_q <= accept;
        if (accept) begin
            s1_we_q   <= req_we;
            s1_err_q  <= req_bad;
            s1_uns_q  <= req_unsigned;
            s1_size_q <= req_size;
            s1_off_q  <= req_off;
        end
    end

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] fmt_data;
    int              nbits;

    always_comb begin
        case (s1_size_q)
            2'b00:   nbits = 8;
            2'b01:   nbits = 16;
            2'b10:   nbits = 32;
            default: nbits = 64;
        endcase
        if (nbits > XLEN) nbits = XLEN;
        shifted  = rd_word >> {s1_off_q, 3'b000};
        fmt_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i < nbits) fmt_data[i] = shifted[i];
            else           fmt_data[i] = !s1_uns_q && shifted[nbits-1];
        end
        if (s1_we_q || s1_err_q) fmt_data = '0;
    end

    logic [FW-1:0] fifo_q [OUT_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] occ_after;
    logic          push;
    logic          pop;
    logic [FW-1:0] head;

    assign push      = s1_valid_q;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (count_q != '0);
    // Everything accepted but not yet consumed lives in S1 or the FIFO, so this
    // bound keeps the FIFO from ever overflowing.
    assign occ_after = count_q + CW'(s1_valid_q) - CW'(pop);
    assign req_ready = !rst && (occ_after < CW'(OUT_DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = (wr_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {s1_we_q, s1_err_q, fmt_data};
    end

    assign head      = fifo_q[rd_ptr_q];
    assign rsp_rdata = rsp_valid ? head[XLEN-1:0] : '0;
    assign rsp_err   = rsp_valid && head[XLEN];
    assign rsp_we    = rsp_valid && head[XLEN+1];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-array reference model with a per-cycle compare,
// directed scenarios with literal expectations, random traffic, and a 64-bit instance.
module tb_dmem_ctrl;
    localparam int DEPTH     = 64;
    localparam int NB        = 4;
    localparam int AW        = 8;
    localparam int OUT_DEPTH = 2;
    localparam int W_AW      = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [AW-1:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_we;

    logic        w_req_valid, w_req_ready, w_req_we, w_req_unsigned;
    logic [W_AW-1:0] w_req_addr;
    logic [1:0]  w_req_size;
    logic [63:0] w_req_wdata, w_rsp_rdata;
    logic        w_rsp_valid, w_rsp_ready, w_rsp_err, w_rsp_we;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(DEPTH), .XLEN(32), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_we(rsp_we)
    );

    dmem_ctrl #(.DEPTH(16), .XLEN(64), .OUT_DEPTH(2)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
        .req_addr(w_req_addr), .req_size(w_req_size), .req_unsigned(w_req_unsigned),
        .req_wdata(w_req_wdata),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_rdata(w_rsp_rdata),
        .rsp_err(w_rsp_err), .rsp_we(w_rsp_we)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  mem_b [DEPTH*NB];
    logic [33:0] exp_q[$];
    int          exp_t_q[$];
    logic [33:0] act_q[$];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed little-endian memory; result packed {we, err, data}.
    function automatic logic [33:0] model_access(input logic we, input logic [AW-1:0] addr,
                                                 input logic [1:0] size, input logic uns,
                                                 input logic [31:0] wd);
        int nb;
        logic [31:0] v;
        nb = 1 << size;
        v  = '0;
        if (size == 2'b11 || (int'(addr) % nb) != 0) return {we, 1'b1, 32'h0};
        if (we) begin
            for (int k = 0; k < nb; k++) mem_b[int'(addr) + k] = wd[8*k +: 8];
            return {1'b1, 1'b0, 32'h0};
        end
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_b[int'(addr) + k];
        if (!uns && v[8*nb-1]) for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
        return {1'b0, 1'b0, v};
    endfunction

    // A response accepted at edge t is presentable from the cycle after edge t+1.
    function automatic bit model_valid();
        if (exp_q.size() == 0) return 1'b0;
        return cyc >= exp_t_q[0] + 1;
    endfunction

    initial begin : model_proc
        bit mv;
        int n;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                exp_t_q.delete();
            end else begin
                mv = model_valid();
                n  = exp_q.size() - ((mv && rsp_ready) ? 1 : 0);
                if (mv && rsp_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_t_q.pop_front());
                end
                if (req_valid && n < OUT_DEPTH) begin
                    exp_q.push_back(model_access(req_we, req_addr, req_size, req_unsigned, req_wdata));
                    exp_t_q.push_back(cyc + 1);
                end
            end
            cyc++;
        end
    end

    initial begin : compare_proc
        bit mv;
        int n;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mv = model_valid();
                n  = exp_q.size() - ((mv && rsp_ready) ? 1 : 0);
                check("rsp_valid", 66'(rsp_valid), 66'(mv));
                check("req_ready", 66'(req_ready), 66'(n < OUT_DEPTH));
                if (mv) begin
                    check("rsp_we", 66'(rsp_we), 66'(exp_q[0][33]));
                    check("rsp_err", 66'(rsp_err), 66'(exp_q[0][32]));
                    check("rsp_rdata", 66'(rsp_rdata), 66'(exp_q[0][31:0]));
                end
                if (rsp_valid && rsp_ready) act_q.push_back({rsp_we, rsp_err, rsp_rdata});
            end
        end
    end

    task automatic send(input logic we, input int addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
        bit acc;
        int budget;
        acc = 1'b0;
        budget = 40;
        req_valid = 1'b1; req_we = we; req_addr = AW'(addr);
        req_size = size; req_unsigned = uns; req_wdata = wd;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            budget--;
        end
        check("send_accept", 66'(acc), 66'(1));
        req_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n);
        int budget;
        budget = 60;
        while (act_q.size() < n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("rsp_count", 66'(act_q.size()), 66'(n));
    endtask

    task automatic expect_rsp(input string name, input logic we, input logic err, input logic [31:0] d);
        logic [33:0] a;
        a = (act_q.size() > 0) ? act_q.pop_front() : 34'h3_FFFF_FFFF;
        check(name, 66'(a), 66'({we, err, d}));
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("drain", 66'(exp_q.size()), 66'(0));
        act_q.delete();
    endtask

    task automatic w_access(input logic we, input int addr, input logic [1:0] size,
                            input logic uns, input logic [63:0] wd, output logic [65:0] r);
        bit acc;
        bit got;
        int budget;
        acc = 1'b0; got = 1'b0; budget = 20;
        r = '1;
        w_req_valid = 1'b1; w_req_we = we; w_req_addr = W_AW'(addr);
        w_req_size = size; w_req_unsigned = uns; w_req_wdata = wd;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = w_req_ready;
            @(posedge clk); #1;
            budget--;
        end
        w_req_valid = 1'b0;
        budget = 10;
        while (!got && budget > 0) begin
            @(negedge clk);
            if (w_rsp_valid) begin
                r = {w_rsp_we, w_rsp_err, w_rsp_rdata};
                got = 1'b1;
            end
            @(posedge clk); #1;
            budget--;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [65:0] r;
        int acc_n;
        int cycles;
        int vcount;
        bit acc;
        int a;

        req_valid = 0; req_we = 0; req_addr = '0; req_size = 0; req_unsigned = 0;
        req_wdata = '0; rsp_ready = 1;
        w_req_valid = 0; w_req_we = 0; w_req_addr = '0; w_req_size = 0; w_req_unsigned = 0;
        w_req_wdata = '0; w_rsp_ready = 1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 66'(rsp_valid), 66'(0));
        check("rst_rsp_rdata", 66'(rsp_rdata), 66'(0));
        check("rst_rsp_err", 66'(rsp_err), 66'(0));
        check("rst_rsp_we", 66'(rsp_we), 66'(0));
        check("rst_req_ready", 66'(req_ready), 66'(1));
        @(posedge clk); #1;

        // 64-bit instance: double store, then narrower loads from upper lanes.
        w_access(1, 'h08, 2'b11, 0, 64'h0123456789ABCDEF, r);
        check("x64_store", r, {1'b1, 1'b0, 64'h0});
        w_access(0, 'h0C, 2'b10, 0, 64'h0, r);
        check("x64_lw_0c", r, {1'b0, 1'b0, 64'h0000000001234567});
        w_access(0, 'h0E, 2'b01, 1, 64'h0, r);
        check("x64_lhu_0e", r, {1'b0, 1'b0, 64'h0000000000000123});
        w_access(0, 'h08, 2'b00, 0, 64'h0, r);
        check("x64_lb_08", r, {1'b0, 1'b0, 64'hFFFFFFFFFFFFFFEF});
        w_access(0, 'h0C, 2'b11, 0, 64'h0, r);
        check("x64_ld_misaligned", r, {1'b0, 1'b1, 64'h0});

        // Preload so the reference and the BRAM agree everywhere.
        for (int w = 0; w < DEPTH; w++) send(1, 4*w, 2'b10, 0, $urandom());
        drain();

        // Sub-word loads with extension, plus exact latency.
        send(1, 'h10, 2'b10, 0, 32'hDEADBEEF);
        drain();
        send(0, 'h13, 2'b00, 0, 32'h0);
        @(negedge clk);
        check("lat_cycle1", 66'(rsp_valid), 66'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_cycle2", 66'(rsp_valid), 66'(1));
        @(posedge clk); #1;
        send(0, 'h12, 2'b00, 1, 32'h0);
        send(0, 'h12, 2'b01, 0, 32'h0);
        wait_rsps(3);
        expect_rsp("lb_13", 0, 0, 32'hFFFFFFDE);
        expect_rsp("lbu_12", 0, 0, 32'h000000AD);
        expect_rsp("lh_12", 0, 0, 32'hFFFFDEAD);

        // Byte store into the middle of a word leaves other lanes alone.
        act_q.delete();
        send(1, 'h20, 2'b10, 0, 32'h11223344);
        send(1, 'h21, 2'b00, 0, 32'h7777775A);
        send(0, 'h20, 2'b10, 0, 32'h0);
        wait_rsps(3);
        expect_rsp("sw_20", 1, 0, 32'h0);
        expect_rsp("sb_21", 1, 0, 32'h0);
        expect_rsp("lw_20", 0, 0, 32'h11225A44);

        // Misaligned and illegal-size accesses.
        act_q.delete();
        send(1, 'h00, 2'b10, 0, 32'hCAFEF00D);
        send(1, 'h01, 2'b01, 0, 32'h0000FFFF);
        send(0, 'h06, 2'b10, 0, 32'h0);
        send(0, 'h08, 2'b11, 0, 32'h0);
        send(0, 'h00, 2'b10, 0, 32'h0);
        wait_rsps(5);
        expect_rsp("sw_00", 1, 0, 32'h0);
        expect_rsp("sh_01_err", 1, 1, 32'h0);
        expect_rsp("lw_06_err", 0, 1, 32'h0);
        expect_rsp("ld_08_err", 0, 1, 32'h0);
        expect_rsp("lw_00_unchanged", 0, 0, 32'hCAFEF00D);

        // Backpressure: six loads against a stalled consumer.
        for (int i = 0; i < 6; i++) send(1, 'h40 + 4*i, 2'b10, 0, 32'hA0000000 + i);
        drain();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        acc_n = 0;
        req_addr = AW'('h40);
        repeat (6) begin
            @(negedge clk);
            if (req_ready) acc_n++;
            @(posedge clk); #1;
            req_addr = AW'('h40 + 4*acc_n);
        end
        check("bp_accepts", 66'(acc_n), 66'(2));
        @(negedge clk);
        check("bp_ready_low", 66'(req_ready), 66'(0));
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        cycles = 0;
        while (acc_n < 6 && cycles < 20) begin
            @(negedge clk);
            if (req_ready) acc_n++;
            @(posedge clk); #1;
            cycles++;
            req_addr = AW'('h40 + 4*acc_n);
        end
        req_valid = 1'b0;
        check("bp_release_cycles", 66'(cycles), 66'(4));
        wait_rsps(6);
        for (int i = 0; i < 6; i++) expect_rsp("bp_order", 0, 0, 32'hA0000000 + i);

        // Reset with two loads in flight; an earlier store must survive.
        act_q.delete();
        send(1, 'h30, 2'b10, 0, 32'h13579BDF);
        send(0, 'h20, 2'b10, 0, 32'h0);
        send(0, 'h24, 2'b10, 0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 66'(rsp_valid), 66'(0));
        check("post_rst_ready", 66'(req_ready), 66'(1));
        vcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        check("post_rst_no_rsp", 66'(vcount), 66'(0));
        @(posedge clk); #1;
        act_q.delete();
        send(0, 'h30, 2'b10, 0, 32'h0);
        wait_rsps(1);
        expect_rsp("post_rst_lw_30", 0, 0, 32'h13579BDF);

        // Random traffic against the reference, with random consumer stalls.
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (!req_valid || acc) begin
                req_valid    = ($urandom_range(0, 9) < 7);
                req_we       = 1'($urandom_range(0, 1));
                req_size     = 2'($urandom_range(0, 3));
                req_unsigned = 1'($urandom_range(0, 1));
                req_wdata    = $urandom();
                a = int'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) a = a & ~((1 << req_size) - 1);
                req_addr = AW'(a);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the RV32I/RV64I core load-store unit. It wraps a single-port byte-enable BRAM behind a valid/ready request channel and a valid/ready response channel. It aligns byte, half, word and double stores to the correct lanes, and shifts and sign/zero-extends loads from any lane. It flags misaligned accesses instead of performing them, and buffers responses so the consumer can stall without losing data.

Parameters:
DEPTH, 4096, number of XLEN-wide memory words
XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8 byte lanes, OFFW = log2(NB)
OUT_DEPTH, 2, response FIFO entries; minimum 2
AW (localparam), $clog2(DEPTH*NB), byte-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_addr  in  AW  byte address; word index = req_addr[AW-1:OFFW], offset = req_addr[OFFW-1:0]
req_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only)
req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
req_wdata  in  XLEN  store data, right-justified
rsp_valid  out  1  response at FIFO head
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  XLEN  load result (0 for stores and errors)
rsp_err  out  1  misaligned or illegal-size access
rsp_we  out  1  echo of req_we for the response

Behaviour:
- Accept: a request is taken on a clk edge with req_valid && req_ready. Exactly one response is produced per accepted request, in order.
- Alignment: an access is legal when offset mod size-bytes == 0. Size 11 is illegal when XLEN=32. An illegal access does no BRAM write and returns rsp_err=1 with rsp_rdata=0.
- Store: byte_we = ((1<<sizebytes)-1) << offset. Write data = req_wdata replicated across all lanes, so each enabled lane carries the right-justified bytes. The BRAM write commits on the accept edge.
- Load pipeline:
  - S0 (accept edge): BRAM read is issued.
  - S1 (next cycle): BRAM data is valid. Format it as (data >> 8*offset), truncate to size, extend by req_unsigned, and push it into the FIFO at the end of S1.
  - Offset, size, unsigned, we and err are carried in S1 registers alongside the read.
- Latency: a request accepted at edge T produces rsp_valid in the cycle after edge T+1 (2 cycles) when the FIFO was empty. Stores and errors follow the same 2-cycle path, so ordering is preserved.
- Read-after-write: a load accepted on the edge after a store to the same word returns the new data.
- Flow control:
  - occupancy = s1_valid + fifo_count.
  - pop = rsp_valid && rsp_ready.
  - req_ready = (occupancy - pop) < OUT_DEPTH, computed combinationally.
  - Sustained throughput is 1 request/cycle while rsp_ready=1.
  - The FIFO never overflows. A push and a pop in the same cycle keep fifo_count unchanged.
- Response outputs: rsp_rdata, rsp_err and rsp_we are held stable while rsp_valid && !rsp_ready.
- Reset:
  - Clears s1_valid, fifo_count and FIFO pointers. rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_we=0, req_ready=1 in the first cycle after reset.
  - In-flight requests are discarded. A store already committed stays committed.
  - BRAM contents are not cleared.
  - A request presented while rst=1 is not accepted and is not written.

Test Plan:
- XLEN=32: store word 0xDEADBEEF @0x10, then load byte @0x13 with signed, byte @0x12 with unsigned, and half @0x12 with signed -> 0xFFFFFFDE, 0x000000AD, 0xFFFFDEAD, each rsp_err=0, 2-cycle latency.
- Store byte 0x5A @0x21 over word 0x11223344 @0x20, then load word @0x20 -> 0x11225A44; the other lanes are untouched.
- Misalignment: half store @0x01, word load @0x06, size 11 with XLEN=32 -> each rsp_err=1, rsp_rdata=0; a following word load shows memory unchanged.
- Backpressure: issue 6 back-to-back loads with rsp_ready=0 -> req_ready drops after 2 accepts. Release rsp_ready -> all 6 responses arrive in order, none lost or duplicated, then 1/cycle throughput.
- XLEN=64: store double 0x0123456789ABCDEF @0x08, then load word @0x0C signed and half @0x0E unsigned -> 0x0000000001234567, 0x0000000000000123.
- Reset mid-stream: assert rst for 1 cycle with 2 loads in flight -> no rsp_valid for them, req_ready=1 after reset, and a prior committed store is still readable.
